uart_tx_sequencer: RTL and testbench
====================================

Name: uart_tx_sequencer

Overview:
- Transmit-side controller for the 16-deep UART byte FIFO.
- Pops one byte at a time from the show-ahead FIFO (read data valid whenever not empty).
- Serializes each byte as an asynchronous UART frame: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits between the TX FIFO and the txd pad; sole owner of the FIFO pop strobe.

Parameters:
DIV_WIDTH, 16, width of the baud divisor (clock cycles per bit)
DATA_WIDTH, 8, frame data bits; fixed at 8, other values unsupported

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
enable  input  1  permits new frames to start; a frame in progress always completes
baud_div  input  DIV_WIDTH  clock cycles per bit; values 0 and 1 are treated as 2
parity_en  input  1  1 = insert parity bit after data
parity_odd  input  1  1 = odd parity, 0 = even
stop2  input  1  1 = two stop bits, 0 = one
fifo_empty  input  1  FIFO empty flag
fifo_data  input  8  FIFO head byte (show-ahead)
fifo_pop  output  1  one-cycle pop strobe to FIFO
txd  output  1  serial line, idle high (mark)
busy  output  1  high while state != IDLE
tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, txd=1, busy=0, tx_done=0, fifo_pop=0, all counters 0. Reset mid-frame aborts the frame. The popped byte is lost.
- States: IDLE, START, DATA, PARITY, STOP.
- fifo_pop = (state==IDLE) && enable && !fifo_empty.
  - Decoded from the state register and inputs only. No path from baud_div or the parity/stop inputs.
- On a pop edge:
  - fifo_data is loaded into the shift register.
  - baud_div (clamped), parity_en, parity_odd and stop2 are latched into shadow registers.
  - State goes to START.
  - Input changes after this edge do not affect the current frame.
- txd is registered.
  - IDLE drives 1.
  - START drives 0.
  - DATA drives shift[0].
  - PARITY drives (XOR of the 8 data bits) XOR parity_odd.
  - STOP drives 1.
- Baud counter counts 0..D-1, where D is the latched clamped divisor. Each bit lasts exactly D cycles. The first START cycle is the cycle after the pop edge.
- DATA: bit counter 0..7. The shift register shifts right at the end of each bit. After bit 7 go to PARITY if parity_en, else STOP.
- PARITY: one bit period, then STOP.
- STOP: D cycles, or 2D if stop2.
  - tx_done=1 on the final cycle of STOP.
  - Next state is IDLE.
- Frame length from first START cycle to end of STOP: (10 + parity_en + stop2) x D cycles.
- Back-to-back frames have exactly one IDLE cycle (txd=1) between frames. The pop occurs in that IDLE cycle.
- Exactly one fifo_pop per frame. Never asserted when fifo_empty=1 or enable=0.
- enable deasserted mid-frame: the frame finishes normally, then the block stays in IDLE.
- fifo_empty rising mid-frame: no effect on the frame in progress.
- busy=0 only in IDLE. tx_done and fifo_pop are never high in the same cycle.
- Target size: 150-250 lines of RTL.

Test Plan:
- Reset: hold rstn=0 with fifo non-empty and enable=1 -> txd=1, busy=0, fifo_pop=0, tx_done=0 throughout.
- Single frame, byte 0xA5, D=4, no parity, 1 stop:
  - Exactly one fifo_pop.
  - txd bit sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles total).
  - tx_done on cycle 40. busy high for all 40 cycles.
- Parity, byte 0x07, D=2:
  - parity_odd=0 -> parity bit 1.
  - parity_odd=1 -> parity bit 0.
  - Frame length 22 cycles. With stop2=1, 24 cycles.
- Back-to-back, FIFO preloaded with 0x11, 0x22, 0x33, D=3:
  - 3 pops, 3 tx_done pulses.
  - Each frame 30 cycles, one idle cycle between frames.
  - No 4th pop after fifo_empty rises.
- Mid-frame changes, D=4: during bit 3, set baud_div=8, parity_en=1 and enable=0:
  - Current frame completes at D=4, no parity.
  - No further pop. txd stays 1.
- Clamp and abort:
  - baud_div=0 -> 2-cycle bits.
  - Assert rstn=0 during DATA -> txd=1 and busy=0 immediately (asynchronous). No tx_done.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// UART transmit sequencer: pops bytes from a show-ahead TX FIFO and serializes
// them as start / 8 data (LSB first) / optional parity / 1 or 2 stop bits.
module uart_tx_sequencer #(
  parameter int DIV_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_pop,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Frame settings captured on the pop edge; later input changes never reach
  // the frame in flight.
  typedef struct packed {
    logic [DIV_WIDTH-1:0] div;
    logic                 par_en;
    logic                 par_bit;
    logic                 stop2;
  } cfg_t;

  state_t                state, state_nxt;
  cfg_t                  cfg;
  logic [DATA_WIDTH-1:0] shift, shift_nxt;
  logic [DIV_WIDTH-1:0]  baud_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic                  txd_q, txd_nxt;
  logic                  pop, baud_end, last_bit, last_stop;

  assign pop       = rstn && (state == IDLE) && enable && !fifo_empty;
  assign baud_end  = (baud_cnt == cfg.div - DIV_WIDTH'(1));
  assign last_bit  = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign last_stop = !cfg.stop2 || stop_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = START;
      START:   if (baud_end) state_nxt = DATA;
      DATA:    if (baud_end && last_bit) state_nxt = cfg.par_en ? PARITY : STOP;
      PARITY:  if (baud_end) state_nxt = STOP;
      STOP:    if (baud_end && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fifo_pop = pop;
    busy     = (state != IDLE);
    tx_done  = (state == STOP) && baud_end && last_stop;
    txd      = txd_q;
  end

  // txd is registered, so it is computed from the state being entered.
  always_comb begin
    shift_nxt = shift;
    if (pop)                          shift_nxt = fifo_data;
    else if (state == DATA && baud_end) shift_nxt = shift >> 1;
    txd_nxt = 1'b1;
    case (state_nxt)
      START:   txd_nxt = 1'b0;
      DATA:    txd_nxt = shift_nxt[0];
      PARITY:  txd_nxt = cfg.par_bit;
      default: txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg      <= '0;
      shift    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      shift <= shift_nxt;
      txd_q <= txd_nxt;
      if (pop) begin
        cfg.div     <= (baud_div < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : baud_div;
        cfg.par_en  <= parity_en;
        cfg.par_bit <= (^fifo_data) ^ parity_odd;
        cfg.stop2   <= stop2;
      end
      if (state == IDLE || baud_end) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + DIV_WIDTH'(1);
      if (state != DATA)  bit_cnt <= '0;
      else if (baud_end)  bit_cnt <= bit_cnt + BW'(1);
      if (state != STOP)  stop_cnt <= 1'b0;
      else if (baud_end)  stop_cnt <= ~stop_cnt;
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench for uart_tx_sequencer: queue-backed show-ahead FIFO model,
// per-frame bit capture against hand-built frame vectors.
module tb_uart_tx_sequencer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [15:0] baud_div;
  logic        parity_en, parity_odd, stop2;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data  = 8'h00;
  logic        fifo_pop, txd, busy, tx_done;

  logic [7:0] q[$];
  int n_cmp = 0, n_err = 0;
  int pop_cnt = 0, done_cnt = 0, overlap = 0, bad_pop = 0;

  uart_tx_sequencer #(.DIV_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .txd(txd), .busy(busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // FIFO model and event counters: sample at negedge, retire the head after the pop edge.
  always begin
    logic pend;
    @(negedge clk);
    pend = fifo_pop;
    if (fifo_pop) pop_cnt++;
    if (tx_done) done_cnt++;
    if (fifo_pop && tx_done) overlap++;
    if (fifo_pop && (fifo_empty || !enable)) bad_pop++;
    @(posedge clk); #1;
    if (pend && q.size() > 0) void'(q.pop_front());
    fifo_empty = (q.size() == 0);
    fifo_data  = (q.size() > 0) ? q[0] : 8'h00;
  end

  // Waits for a pop, then captures one frame cycle by cycle. bits[k] is frame bit k.
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits,
                             input int d, input int chg_cyc, output int waits);
    logic [15:0] obs;
    int glitch, busy_lo, done_n, done_at;
    logic idle_txd, idle_busy;
    obs = '0; glitch = 0; busy_lo = 0; done_n = 0; done_at = -1; waits = 0;
    do begin @(negedge clk); waits++; end while (!fifo_pop && waits < 100);
    if (!fifo_pop) begin
      chk({tag, ".pop_timeout"}, 0, 1);
      return;
    end
    idle_txd = txd; idle_busy = busy;
    for (int c = 0; c < nbits * d; c++) begin
      @(negedge clk);
      if (c % d == 0) obs[c / d] = txd;
      else if (txd !== obs[c / d]) glitch++;
      if (!busy) busy_lo++;
      if (tx_done) begin done_n++; done_at = c; end
      if (c == chg_cyc) begin baud_div = 16'd8; parity_en = 1'b1; enable = 1'b0; end
    end
    chk({tag, ".bits"}, obs, bits);
    chk({tag, ".bit_width"}, glitch, 0);
    chk({tag, ".busy"}, busy_lo, 0);
    chk({tag, ".done_n"}, done_n, 1);
    chk({tag, ".done_at"}, done_at, nbits * d - 1);
    chk({tag, ".idle_txd"}, idle_txd, 1);
    chk({tag, ".idle_busy"}, idle_busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, pb, db;
    rstn = 1'b0; enable = 1'b1; baud_div = 16'd4;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    q.push_back(8'hA5);

    // reset held with data available and enable high
    repeat (3) begin
      @(negedge clk);
      chk("rst.txd", txd, 1); chk("rst.busy", busy, 0);
      chk("rst.pop", fifo_pop, 0); chk("rst.done", tx_done, 0);
    end
    chk("rst.fifo_visible", fifo_empty, 0);

    // 0xA5, D=4, no parity, 1 stop: 0,1,0,1,0,0,1,0,1,1
    @(posedge clk); #1 rstn = 1'b1;
    check_frame("a5", {1'b1, 8'hA5, 1'b0}, 10, 4, -1, w);
    chk("a5.pops", pop_cnt, 1);

    // 0x07, D=2, even parity -> parity bit 1, 22 cycles
    @(posedge clk); #1;
    baud_div = 16'd2; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b0;
    q.push_back(8'h07);
    check_frame("par_even", {1'b1, 1'b1, 8'h07, 1'b0}, 11, 2, -1, w);

    // 0x07, D=2, odd parity -> parity bit 0, two stops, 24 cycles
    @(posedge clk); #1;
    parity_odd = 1'b1; stop2 = 1'b1;
    q.push_back(8'h07);
    check_frame("par_odd2", {1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 12, 2, -1, w);

    // back-to-back, D=3: one idle cycle between frames
    @(posedge clk); #1;
    enable = 1'b0; baud_div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
    repeat (3) @(posedge clk);
    #1; pb = pop_cnt; db = done_cnt; enable = 1'b1;
    check_frame("b2b0", {1'b1, 8'h11, 1'b0}, 10, 3, -1, w);
    check_frame("b2b1", {1'b1, 8'h22, 1'b0}, 10, 3, -1, w);
    chk("b2b1.gap", w, 1);
    check_frame("b2b2", {1'b1, 8'h33, 1'b0}, 10, 3, -1, w);
    chk("b2b2.gap", w, 1);
    repeat (10) @(negedge clk);
    chk("b2b.pops", pop_cnt - pb, 3);
    chk("b2b.dones", done_cnt - db, 3);
    chk("b2b.idle_txd", txd, 1);

    // mid-frame: divisor/parity/enable change during data bit 3
    @(posedge clk); #1;
    pb = pop_cnt; baud_div = 16'd4; parity_en = 1'b0;
    q.push_back(8'h5A); q.push_back(8'hC3);
    check_frame("mid", {1'b1, 8'h5A, 1'b0}, 10, 4, 17, w);
    repeat (20) @(negedge clk);
    chk("mid.pops", pop_cnt - pb, 1);
    chk("mid.txd", txd, 1);
    chk("mid.busy", busy, 0);
    chk("mid.pending", fifo_empty, 0);

    // divisor 0 clamps to 2-cycle bits
    @(posedge clk); #1;
    baud_div = 16'd0; parity_en = 1'b0; enable = 1'b1;
    check_frame("clamp", {1'b1, 8'hC3, 1'b0}, 10, 2, -1, w);

    // asynchronous abort during DATA
    @(posedge clk); #1;
    baud_div = 16'd4; pb = pop_cnt; db = done_cnt;
    q.push_back(8'h00);
    w = 0;
    do begin @(negedge clk); w++; end while (!fifo_pop && w < 100);
    chk("abort.pop_seen", fifo_pop, 1);
    repeat (10) @(negedge clk);
    chk("abort.pre_txd", txd, 0);
    chk("abort.pre_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("abort.txd", txd, 1);
    chk("abort.busy", busy, 0);
    chk("abort.pop", fifo_pop, 0);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort.dones", done_cnt - db, 0);
    chk("abort.pops", pop_cnt - pb, 1);
    chk("abort.idle_txd", txd, 1);
    chk("abort.idle_busy", busy, 0);

    chk("pop_with_done", overlap, 0);
    chk("pop_illegal", bad_pop, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
